// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Decode-stage RAW hazard detector built on a DEPTH-slot shift
//                scoreboard of in-flight register writes. Generates decode
//                stall, fetch/decode flush on redirect, a pending-write mask
//                and a saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
   parameter int REG_BITS  = 3,
   parameter int DEPTH     = 3,
   parameter int FWD       = 1,
   parameter int BYPASS_WB = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid,
   input  logic [REG_BITS-1:0]    id_src0,
   input  logic [REG_BITS-1:0]    id_src1,
   input  logic [REG_BITS-1:0]    id_src2,
   input  logic                   id_src0_v,
   input  logic                   id_src1_v,
   input  logic                   id_src2_v,
   input  logic                   id_early,
   input  logic [REG_BITS-1:0]    id_dst,
   input  logic                   id_dst_v,
   input  logic                   id_is_load,
   input  logic                   pipe_hold,
   input  logic                   redirect,
   output logic                   stall_decode,
   output logic                   flush_fetch,
   output logic                   flush_decode,
   output logic [2**REG_BITS-1:0] pending_mask,
   output logic [15:0]            stall_count
);

   localparam int NREGS = 2**REG_BITS;
   // With a write-before-read register file the WB slot is already visible.
   localparam int WIN   = (BYPASS_WB != 0) ? DEPTH - 1 : DEPTH;

   // Scoreboard slots: index 0 is EX, index DEPTH-1 is WB.
   logic [DEPTH-1:0]    r_valid;
   logic [DEPTH-1:0]    r_dst_v;
   logic [DEPTH-1:0]    r_load;
   logic [REG_BITS-1:0] r_dst [DEPTH];
   logic [15:0]         r_stall_count;

   logic [DEPTH-1:0]    w_win;
   logic [DEPTH-1:0]    w_m0;
   logic [DEPTH-1:0]    w_m1;
   logic [DEPTH-1:0]    w_m2;
   logic                w_nofwd_hit;
   logic                w_early_hit;
   logic                w_load_use;
   logic                w_cond;
   logic                w_hazard;
   logic                w_issue;
   logic                w_count_en;
   logic [NREGS-1:0]    w_mask;

   // Per-slot source matches and hazard-window membership.
   generate
      for (genvar k = 0; k < DEPTH; k++) begin : g_match
         assign w_win[k] = (k < WIN) ? 1'b1 : 1'b0;
         assign w_m0[k]  = id_src0_v & r_valid[k] & r_dst_v[k] & (r_dst[k] == id_src0);
         assign w_m1[k]  = id_src1_v & r_valid[k] & r_dst_v[k] & (r_dst[k] == id_src1);
         assign w_m2[k]  = id_src2_v & r_valid[k] & r_dst_v[k] & (r_dst[k] == id_src2);
      end
   endgenerate

   // An early (decode-consumed) src0 cannot use forwarding, so it always
   // follows the no-forwarding rule; otherwise only load-use stalls with FWD.
   assign w_nofwd_hit = |((w_m0 | w_m1 | w_m2) & w_win);
   assign w_early_hit = |(w_m0 & w_win);
   assign w_load_use  = (w_m0[0] | w_m1[0] | w_m2[0]) & r_load[0];
   assign w_cond      = (FWD == 0) ? w_nofwd_hit : (w_load_use | (id_early & w_early_hit));
   assign w_hazard    = id_valid & w_cond;
   assign w_issue     = id_valid & ~w_hazard & ~redirect & ~pipe_hold;
   assign w_count_en  = w_hazard & ~pipe_hold & ~redirect & (r_stall_count != 16'hFFFF);

   assign stall_decode = w_hazard | pipe_hold;
   assign flush_fetch  = redirect & ~pipe_hold;
   assign flush_decode = redirect & ~pipe_hold;
   assign stall_count  = r_stall_count;
   assign pending_mask = w_mask;

   // Slot 0 captures the issuing instruction or a bubble unless frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid[0] <= 1'b0;
         r_dst_v[0] <= 1'b0;
         r_load[0]  <= 1'b0;
         r_dst[0]   <= '0;
      end else if (!pipe_hold) begin
         r_valid[0] <= w_issue;
         r_dst_v[0] <= id_dst_v;
         r_load[0]  <= id_is_load;
         r_dst[0]   <= id_dst;
      end
   end

   // Older slots shift one stage toward WB on every unheld edge.
   generate
      for (genvar k = 1; k < DEPTH; k++) begin : g_shift
         // Slot k takes over the contents of slot k-1.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid[k] <= 1'b0;
               r_dst_v[k] <= 1'b0;
               r_load[k]  <= 1'b0;
               r_dst[k]   <= '0;
            end else if (!pipe_hold) begin
               r_valid[k] <= r_valid[k-1];
               r_dst_v[k] <= r_dst_v[k-1];
               r_load[k]  <= r_load[k-1];
               r_dst[k]   <= r_dst[k-1];
            end
         end
      end
   endgenerate

   // Pending-write mask: OR of one-hot destinations of live writing slots.
   always_comb begin
      w_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (r_valid[k] && r_dst_v[k]) begin
            w_mask[r_dst[k]] = 1'b1;
         end
      end
   end

   // Saturating count of cycles lost to genuine hazard stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_count <= '0;
      end else if (w_count_en) begin
         r_stall_count <= r_stall_count + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Directed self-checking bench; one no-forwarding instance and
//                one full-forwarding instance share the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [2:0] id_src0, id_src1, id_src2, id_dst;
   logic       id_src0_v, id_src1_v, id_src2_v, id_early, id_dst_v, id_is_load;
   logic       pipe_hold, redirect;

   logic        stall_nf, ffetch_nf, fdec_nf;
   logic [7:0]  mask_nf;
   logic [15:0] cnt_nf;
   logic        stall_f, ffetch_f, fdec_f;
   logic [7:0]  mask_f;
   logic [15:0] cnt_f;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.REG_BITS(3), .DEPTH(3), .FWD(0), .BYPASS_WB(1)) dut_nf (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_src0(id_src0), .id_src1(id_src1), .id_src2(id_src2),
      .id_src0_v(id_src0_v), .id_src1_v(id_src1_v), .id_src2_v(id_src2_v),
      .id_early(id_early), .id_dst(id_dst), .id_dst_v(id_dst_v),
      .id_is_load(id_is_load), .pipe_hold(pipe_hold), .redirect(redirect),
      .stall_decode(stall_nf), .flush_fetch(ffetch_nf), .flush_decode(fdec_nf),
      .pending_mask(mask_nf), .stall_count(cnt_nf)
   );

   hazard_scoreboard #(.REG_BITS(3), .DEPTH(3), .FWD(1), .BYPASS_WB(1)) dut_f (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_src0(id_src0), .id_src1(id_src1), .id_src2(id_src2),
      .id_src0_v(id_src0_v), .id_src1_v(id_src1_v), .id_src2_v(id_src2_v),
      .id_early(id_early), .id_dst(id_dst), .id_dst_v(id_dst_v),
      .id_is_load(id_is_load), .pipe_hold(pipe_hold), .redirect(redirect),
      .stall_decode(stall_f), .flush_fetch(ffetch_f), .flush_decode(fdec_f),
      .pending_mask(mask_f), .stall_count(cnt_f)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle();
      id_valid = 1'b0; id_src0 = 3'd0; id_src1 = 3'd0; id_src2 = 3'd0;
      id_src0_v = 1'b0; id_src1_v = 1'b0; id_src2_v = 1'b0; id_early = 1'b0;
      id_dst = 3'd0; id_dst_v = 1'b0; id_is_load = 1'b0;
      pipe_hold = 1'b0; redirect = 1'b0;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a plain producer (no sources read).
   task automatic producer(input logic [2:0] dst, input logic ld);
      idle();
      id_valid = 1'b1; id_dst = dst; id_dst_v = 1'b1; id_is_load = ld;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #11;
      chk("reset_mask_nf", mask_nf, 8'h00);
      chk("reset_cnt_f", cnt_f, 16'd0);
      chk("reset_stall_f", stall_f, 1'b0);
      rst_n = 1'b1;
      #2;

      // ---- no forwarding: add r2 then consumer of r2 ----
      producer(3'd2, 1'b0);
      #1 chk("t1_prod_nostall", stall_nf, 1'b0);
      tick();
      producer(3'd3, 1'b0);
      id_src0 = 3'd2; id_src0_v = 1'b1;
      #1 chk("t1_stall_c1", stall_nf, 1'b1);
      chk("t1_mask_r2", mask_nf, 8'h04);
      chk("t1_fwd_nostall", stall_f, 1'b0);
      tick();
      chk("t1_stall_c2", stall_nf, 1'b1);
      tick();
      chk("t1_stall_c3_clear", stall_nf, 1'b0);
      chk("t1_cnt", cnt_nf, 16'd2);
      tick();
      chk("t1_mask_consumer", mask_nf, 8'h08);
      chk("t1_cnt_fwd", cnt_f, 16'd0);

      // ---- forwarding: load-use, then non-load producer ----
      do_reset();
      producer(3'd4, 1'b1);
      tick();
      producer(3'd5, 1'b0);
      id_src1 = 3'd4; id_src1_v = 1'b1;
      #1 chk("t2_loaduse_stall", stall_f, 1'b1);
      tick();
      chk("t2_loaduse_clear", stall_f, 1'b0);
      tick();
      producer(3'd4, 1'b0);
      tick();
      producer(3'd5, 1'b0);
      id_src1 = 3'd4; id_src1_v = 1'b1;
      #1 chk("t2_alu_nostall", stall_f, 1'b0);
      chk("t2_cnt", cnt_f, 16'd1);

      // ---- forwarding: jal r7 then early jalr r7 ----
      do_reset();
      producer(3'd7, 1'b0);
      tick();
      producer(3'd7, 1'b0);
      id_src0 = 3'd7; id_src0_v = 1'b1; id_early = 1'b1;
      #1 chk("t3_early_stall_c1", stall_f, 1'b1);
      chk("t3_mask_c1", mask_f, 8'h80);
      tick();
      chk("t3_early_stall_c2", stall_f, 1'b1);
      chk("t3_mask_c2", mask_f, 8'h80);
      tick();
      chk("t3_early_clear", stall_f, 1'b0);
      chk("t3_cnt", cnt_f, 16'd2);

      // ---- hazard together with redirect ----
      do_reset();
      producer(3'd4, 1'b1);
      tick();
      producer(3'd5, 1'b0);
      id_src1 = 3'd4; id_src1_v = 1'b1; redirect = 1'b1;
      #1 chk("t4_flush_fetch", ffetch_f, 1'b1);
      chk("t4_flush_decode", fdec_f, 1'b1);
      tick();
      idle();
      #1 chk("t4_cnt_unchanged", cnt_f, 16'd0);
      chk("t4_bubble_mask", mask_f, 8'h10);

      // ---- pipe_hold with a load in slot 0 ----
      do_reset();
      producer(3'd4, 1'b1);
      tick();
      producer(3'd5, 1'b0);
      id_src1 = 3'd4; id_src1_v = 1'b1; pipe_hold = 1'b1;
      #1 chk("t5_hold_stall", stall_f, 1'b1);
      tick();
      redirect = 1'b1;
      #1 chk("t5_redirect_ignored", ffetch_f, 1'b0);
      chk("t5_mask_h2", mask_f, 8'h10);
      tick();
      redirect = 1'b0;
      tick();
      pipe_hold = 1'b0;
      #1 chk("t5_resume_stall", stall_f, 1'b1);
      chk("t5_cnt_held", cnt_f, 16'd0);
      chk("t5_mask_held", mask_f, 8'h10);
      tick();
      chk("t5_cnt_after", cnt_f, 16'd1);
      chk("t5_stall_clear", stall_f, 1'b0);
      tick();
      chk("t5_mask_issued", mask_f, 8'h30);

      // ---- asynchronous reset mid-stall (no forwarding) ----
      do_reset();
      producer(3'd2, 1'b0);
      tick();
      producer(3'd4, 1'b0);
      tick();
      producer(3'd6, 1'b0);
      id_src0 = 3'd4; id_src0_v = 1'b1;
      #1 chk("t6_stall_pre", stall_nf, 1'b1);
      tick();
      chk("t6_mask_pre", mask_nf, 8'h14);
      chk("t6_cnt_pre", cnt_nf, 16'd1);
      rst_n = 1'b0;
      #1 chk("t6_rst_mask", mask_nf, 8'h00);
      chk("t6_rst_stall", stall_nf, 1'b0);
      chk("t6_rst_cnt", cnt_nf, 16'd0);
      rst_n = 1'b1;
      tick();
      chk("t6_issue_after_rst", mask_nf, 8'h40);
      chk("t6_no_flush", ffetch_nf, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the decode-stage hazard detector. It tracks in-flight register writes in a DEPTH-slot shift scoreboard instead of comparing pipeline-register fields. It raises `stall_decode` for RAW hazards under a selectable forwarding mode, and issues fetch/decode flushes on redirect. It sits beside the ID stage, is fed by the decoder and the EX-stage branch resolution, and produces a pending-write mask and a stall performance counter.

## Interface
- REG_BITS, 3, register index width; register file has 2**REG_BITS entries
- DEPTH, 3, scoreboard slots; slot 0 = EX, slot DEPTH-1 = WB; legal 2..8
- FWD, 1, 1 = full EX/MEM forwarding present, 0 = no forwarding
- BYPASS_WB, 1, 1 = register file is write-before-read, so slot DEPTH-1 never causes a hazard
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- id_valid  input  1  decode holds a real instruction
- id_src0 / id_src1 / id_src2  input  REG_BITS each  source indices (src2 = store data Rd)
- id_src0_v / id_src1_v / id_src2_v  input  1 each  source actually read
- id_early  input  1  src0 is consumed in decode (jr/jalr); forwarding is unusable for it
- id_dst  input  REG_BITS  destination index (decoder supplies 7 for jal/jalr, Rs for lbi/slbi/stu)
- id_dst_v  input  1  instruction writes id_dst
- id_is_load  input  1  instruction is a load
- pipe_hold  input  1  downstream memory stall; freezes the scoreboard
- redirect  input  1  taken branch/jump resolved in EX this cycle
- stall_decode  output  1  hold PC and IF/ID; decode instruction not issued
- flush_fetch  output  1  squash IF/ID contents
- flush_decode  output  1  insert bubble into ID/EX
- pending_mask  output  2**REG_BITS  bit r set if any valid slot writes r
- stall_count  output  16  saturating count of hazard-stall cycles

## Operation
- Each slot holds {valid, dst_v, dst, is_load}.
- match(s,k) = src_v(s) & slot[k].valid & slot[k].dst_v & (slot[k].dst == s).
- Hazard window W: k in 0..DEPTH-1, excluding DEPTH-1 when BYPASS_WB=1.
- Hazard conditions:
  - FWD=0: hazard if any source matches any slot in W.
  - FWD=1: hazard if any source matches slot 0 with is_load=1 (load-use).
  - Early source (src0 with id_early=1) is checked with the FWD=0 rule regardless of FWD.
- hazard = id_valid & (condition above). Sources with src_v=0 never cause a hazard.
- stall_decode = hazard | pipe_hold.
- flush_fetch = flush_decode = redirect & ~pipe_hold.
- Issue: issue = id_valid & ~hazard & ~redirect & ~pipe_hold.
- Update on every edge with pipe_hold=0:
  - slot[k+1] <= slot[k]; slot DEPTH-1 is discarded.
  - slot[0] <= {1, id_dst_v, id_dst, id_is_load} if issue, else a bubble (valid=0).
- pipe_hold=1: all slots hold; nothing issues; redirect is ignored (its source must keep it asserted until the hold drops).
- Redirect precedence: the decode instruction is squashed (not issued) even if it has a hazard. Older slots are kept; the branch itself is in slot 0 and retires normally.
- stall_count increments on cycles with hazard=1 & pipe_hold=0 & redirect=0, and saturates at 16'hFFFF.
- pending_mask is the OR of one-hot(dst) over slots with valid & dst_v, derived from registered state only.

## Timing
- Reset (rst_n low, asynchronous): all slots invalid and stall_count=0 immediately, so pending_mask=0, and stall_decode=0 and flush outputs=0 unless pipe_hold/redirect are driven. Reset asserted mid-stall clears the stall in the same cycle.
- stall_decode, flush_fetch and flush_decode are combinational from inputs and registered slots, valid in the same cycle with no latency.
- An issued producer enters slot 0 on the next edge and leaves after DEPTH unheld edges.
- Maximum hazard stall, FWD=0 with BYPASS_WB=1: DEPTH-1 cycles.
- Load-use stall with FWD=1: exactly 1 cycle.
- Simultaneous issue into slot 0 and retire from slot DEPTH-1 of the same register: pending_mask keeps the bit set.
- stall_count wrap is not allowed; it holds at the maximum.

## Test plan
- DEPTH=3, FWD=0, BYPASS_WB=1. Issue add with dst=2, then consumer with src0=2 -> stall_decode high for exactly 2 cycles, consumer issues on cycle 3, stall_count=2.
- FWD=1. Load with dst=4, then add with src1=4 -> 1-cycle stall. Non-load producer with dst=4 -> 0 stall.
- FWD=1. jalr with src0=7 (id_early=1) right after jal with dst=7 -> stalls 2 cycles as under FWD=0. pending_mask=8'h80 while jal is in flight.
- Hazard present plus redirect=1 in the same cycle -> flush_fetch=flush_decode=1, nothing issued, stall_count unchanged, next slot 0 is a bubble.
- pipe_hold=1 for 3 cycles with a load in slot 0 -> slots frozen, pending_mask constant, redirect pulse ignored, stall_count unchanged. The load-use stall resumes after the hold drops.
- rst_n low for one cycle mid-stall with pending_mask=8'h14 -> pending_mask=0, stall_decode=0 and stall_count=0 immediately. The next id_valid instruction issues.
